mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the processor's instruction-fetch port and its load/store data port.
- Grants one requester at a time, registers the request onto the memory bus, and waits for the memory acknowledge.
- Returns read data and a one-cycle ack pulse to the granted requester.
- Sits between the Processor core (PC/fetch and load/store paths) and the memory model. The core stalls on a port until that port's ack.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port and the load/store data port. One transaction at a time:
// IDLE (arbitrate) -> BUSY (mem_req held until mem_ack) -> RESP (one-cycle ack).
// Data has priority over fetch. Optional fetch starvation guard is enabled by
// defining MEM_ARB_STARVE_GUARD_EN; the default build has strict data priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                pick_data;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic       starve_hit;

    // Fetch overrides data once it has been bypassed STARVE_MAX times in a row
    assign starve_hit = d_req && if_req && (starve_q == STARVE_LIM);
    assign pick_data  = d_req && !starve_hit;

    // Count data grants made while a fetch is waiting; clear when fetch wins or is idle
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE) begin
            if (!if_req || !pick_data) starve_d = '0;
            else                       starve_d = starve_q + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    logic starve_unused;
    assign starve_unused = |STARVE_MAX;
    assign pick_data     = d_req;
`endif

    // Next-state and registered-output computation for the transaction FSM
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_req || if_req) begin
                    state_d   = ST_BUSY;
                    mem_req_d = 1'b1;
                    if (pick_data) begin
                        owner_d     = OWN_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        owner_d    = OWN_IF;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                // No arbitration here: the retiring request may still be high
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d   = ST_IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // FSM state and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases from the test plan plus a random
// two-requester run, checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0, d_rdata;
    logic          d_ack;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Memory contents: bus-side store (responder) and reference store (model)
    logic [DW-1:0] bus_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction
    function automatic logic [DW-1:0] rd_bus(input logic [AW-1:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_val(a);
    endfunction
    function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    // Reference model state: transaction phase, current grant, starvation count
    int            ph = 0;          // 0 waiting for grant, 1 in memory, 2 retiring
    logic          own_d = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic          m_we = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] exp_if_r = '0;
    int            cnt = 0;
    int            n_grant = 0;
    logic [63:0]   ghist = '0;      // 1 = data grant, newest in bit 0
    logic          if_done = 1'b0, d_done = 1'b0;

    // Inputs as seen by the DUT at the coming edge
    logic          p_if, p_d, p_we, p_ma;
    logic [AW-1:0] p_ia, p_da;
    logic [DW-1:0] p_wd;

    // Memory responder controls
    int mcnt = -1, wait_fix = 0, wait_max = 0;
    bit spur_en = 0;

    task automatic model();
        logic gd;
        if_done = 1'b0;
        d_done  = 1'b0;
        case (ph)
            0: begin
                chk("idle_acks", {if_ack, d_ack}, 2'b00);
                if (p_if || p_d) begin
                    gd = p_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
                    if (p_d && p_if && cnt == SMAX) gd = 1'b0;
`endif
                    if (!gd)      cnt = 0;
                    else if (p_if) cnt++;
                    else          cnt = 0;
                    own_d  = gd;
                    m_addr = gd ? p_da : p_ia;
                    m_we   = gd ? p_we : 1'b0;
                    if (gd) m_wdata = p_wd;
                    n_grant++;
                    ghist = {ghist[62:0], gd};
                    chk("grant_req", mem_req, 1'b1);
                    chk("grant_addr", mem_addr, m_addr);
                    chk("grant_we", mem_we, m_we);
                    chk("grant_wdata", mem_wdata, m_wdata);
                    ph = 1;
                end else begin
                    cnt = 0;
                    chk("idle_req", mem_req, 1'b0);
                end
            end
            1: begin
                if (p_ma) begin
                    chk("ack", {if_ack, d_ack}, own_d ? 2'b01 : 2'b10);
                    chk("ack_mreq", mem_req, 1'b0);
                    if (own_d) begin
                        if (m_we) ref_mem[m_addr] = m_wdata;
                        else      chk("d_rdata", d_rdata, rd_ref(m_addr));
                        d_done = 1'b1;
                    end else begin
                        exp_if_r = rd_ref(m_addr);
                        chk("if_rdata", if_rdata, exp_if_r);
                        if_done = 1'b1;
                    end
                    ph = 2;
                end else begin
                    chk("busy_req", mem_req, 1'b1);
                    chk("busy_addr", mem_addr, m_addr);
                    chk("busy_we", mem_we, m_we);
                    chk("busy_wdata", mem_wdata, m_wdata);
                    chk("busy_acks", {if_ack, d_ack}, 2'b00);
                end
            end
            default: begin
                chk("resp_acks", {if_ack, d_ack}, 2'b00);
                chk("if_hold", if_rdata, exp_if_r);
                ph = 0;
            end
        endcase
    endtask

    task automatic mem_resp();
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (mcnt < 0) mcnt = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, wait_max));
            if (mcnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_bus(mem_addr);
                if (mem_we) bus_mem[mem_addr] = mem_wdata;
                mcnt = -1;
            end else begin
                mcnt--;
            end
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
        end
    endtask

    // One clock: snapshot inputs, cross the edge, check, then drive memory
    task automatic step();
        p_if = if_req; p_d = d_req; p_ia = if_addr; p_da = d_addr;
        p_we = d_we;   p_wd = d_wdata; p_ma = mem_ack;
        @(posedge clk);
        #1;
        model();
        mem_resp();
    endtask

    task automatic wait_done(input logic port_d, input int max, output int n);
        logic dn;
        n  = 0;
        dn = 1'b0;
        while (!dn && n < max) begin
            step();
            n++;
            dn = port_d ? d_done : if_done;
        end
        chk("done", dn, 1'b1);
        if (port_d) d_req = 1'b0;
        else        if_req = 1'b0;
    endtask

    task automatic drain(input int max);
        for (int c = 0; c < max && (if_req || d_req || ph != 0); c++) begin
            step();
            if (if_done) if_req = 1'b0;
            if (d_done)  d_req  = 1'b0;
        end
        chk("drain", {if_req, d_req, ph != 0}, 3'b000);
    endtask

    task automatic drive_rand();
        if (if_done) if_req = 1'b0;
        if (d_done)  d_req  = 1'b0;
        if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = 32'($urandom_range(0, 31)) << 2;
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 32'($urandom_range(0, 31)) << 2;
            d_wdata = $urandom;
        end
    endtask

    initial begin
        int n, d_at, if_at, n_da, n_ia, busy_n, g0;
        logic dn;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mreq", mem_req, 1'b0);
        chk("rst_mwe", mem_we, 1'b0);
        chk("rst_maddr", mem_addr, '0);
        chk("rst_mwdata", mem_wdata, '0);
        chk("rst_acks", {if_ack, d_ack}, 2'b00);
        chk("rst_rdata", {if_rdata, d_rdata}, '0);
        rst_n = 1'b1;
        step();

        // Single fetch, zero-wait memory
        bus_mem[32'h8] = 32'h0040_0093;
        ref_mem[32'h8] = 32'h0040_0093;
        if_addr = 32'h8;
        if_req  = 1'b1;
        wait_done(1'b0, 10, n);
        chk("fetch_lat", n, 2);
        chk("fetch_data", if_rdata, 32'h0040_0093);
        step();

        // Store then load of the same word
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hFFFF_FFFE;
        wait_done(1'b1, 10, n);
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        wait_done(1'b1, 10, n);
        chk("load_back", d_rdata, 32'hFFFF_FFFE);
        step();

        // Collision: data first, fetch at the next IDLE
        if_addr = 32'h20; d_addr = 32'h24; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        d_at = 0; if_at = 0; n_da = 0; n_ia = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (d_done)  begin d_at = c;  n_da++; d_req = 1'b0; end
            if (if_done) begin if_at = c; n_ia++; if_req = 1'b0; end
        end
        chk("coll_d_at", d_at, 2);
        chk("coll_if_at", if_at, 5);
        chk("coll_n_acks", {n_da[7:0], n_ia[7:0]}, 16'h0101);
        chk("coll_order", ghist[1:0], 2'b10);

        // Wait states: 4-cycle memory delay keeps the request up for 5 cycles
        wait_fix = 4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        busy_n = 0; dn = 1'b0;
        for (int c = 0; c < 20 && !dn; c++) begin
            step();
            if (mem_req) busy_n++;
            if (d_done)  dn = 1'b1;
        end
        d_req = 1'b0;
        chk("ws_done", dn, 1'b1);
        chk("ws_busy", busy_n, 5);
        wait_fix = 0;
        step();

        // Spurious mem_ack while idle must not produce an ack
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        chk("spur_acks", {if_ack, d_ack}, 2'b00);

        // Reset while the memory access is in flight
        wait_fix = 3;
        if_addr = 32'h40; if_req = 1'b1;
        step();
        chk("rb_busy", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_mreq", mem_req, 1'b0);
        chk("rb_acks", {if_ack, d_ack}, 2'b00);
        ph = 0; mcnt = -1; mem_ack = 1'b0; m_wdata = '0; exp_if_r = '0; cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_fix = 0;
        wait_done(1'b0, 10, n);
        chk("rb_fetch", if_rdata, rd_ref(32'h40));
        step();

        // Both requesters saturated: grant pattern depends on the starvation guard
        step();
        g0 = n_grant;
        if_req = 1'b1; if_addr = 32'h50;
        d_req = 1'b1;  d_we = 1'b0; d_addr = 32'h54;
        for (int c = 0; c < 60 && (n_grant - g0) < 10; c++) begin
            step();
            if (d_done)  d_addr  = 32'($urandom_range(0, 31)) << 2;
            if (if_done) if_addr = 32'($urandom_range(0, 31)) << 2;
        end
        chk("starve_cnt", n_grant - g0, 10);
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_pat", ghist[9:0], 10'b11110_11110);
`else
        chk("starve_pat", ghist[9:0], 10'b11111_11111);
`endif
        drain(40);

        // Random traffic with random wait states and spurious acks
        wait_fix = -1; wait_max = 3; spur_en = 1;
        for (int c = 0; c < 3000; c++) begin
            drive_rand();
            step();
        end
        spur_en = 0;
        drain(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
